// File: rtl/imem_load_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imem_load_ctrl_pkg
// Description : Shared types, state encodings and helpers for the
//               instruction-memory load controller.
// Revision    : 1.0 - initial release
// ============================================================================
package imem_load_ctrl_pkg;

  // Default instruction memory word-address width (1024 words)
  localparam int IMEM_AW = 10;

  // Controller state encoding
  typedef logic [2:0] state_t;

  localparam state_t ST_BOOT    = 3'd0;
  localparam state_t ST_RUN     = 3'd1;
  localparam state_t ST_DRAIN   = 3'd2;
  localparam state_t ST_PATCH   = 3'd3;
  localparam state_t ST_RESTART = 3'd4;

  // Saturating increment for the 16-bit beat counter
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/imem_load_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : imem_load_ctrl_if
// Description : Loader stream, fetch-side and memory-port signals of the
//               instruction-memory load controller. The controller uses the
//               slave view; the surrounding core/loader uses the master view.
// Revision    : 1.0 - initial release
// ============================================================================
interface imem_load_ctrl_if
  import imem_load_ctrl_pkg::*;
#(
  parameter int AW = IMEM_AW
);

  // Loader stream
  logic          ld_valid;
  logic          ld_ready;
  logic [AW-1:0] ld_addr;
  logic [31:0]   ld_data;
  logic          ld_last;

  // Fetch stage
  logic [31:0]   fetch_addr;
  logic          fetch_stall;
  logic          redirect;
  logic [31:0]   redirect_pc;

  // Memory port
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;

  // Load status
  logic [15:0]   ld_count;
  logic          ld_err;

  modport master (
    output ld_valid, ld_addr, ld_data, ld_last, fetch_addr,
    input  ld_ready, fetch_stall, redirect, redirect_pc,
    input  mem_we, mem_addr, mem_wdata, ld_count, ld_err
  );

  modport slave (
    input  ld_valid, ld_addr, ld_data, ld_last, fetch_addr,
    output ld_ready, fetch_stall, redirect, redirect_pc,
    output mem_we, mem_addr, mem_wdata, ld_count, ld_err
  );

endinterface
`default_nettype wire

// File: rtl/imem_port_mux.sv
`default_nettype none
// ============================================================================
// Module      : imem_port_mux
// Description : Combinational mux sharing the single instruction-memory port
//               between loader writes and fetch reads.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_port_mux
  import imem_load_ctrl_pkg::*;
#(
  parameter int AW = IMEM_AW
) (
  input  wire logic          loader_sel_i,
  input  wire logic          wr_en_i,
  input  wire logic [AW-1:0] ld_addr_i,
  input  wire logic [31:0]   ld_data_i,
  input  wire logic [AW-1:0] fetch_waddr_i,
  output logic               mem_we_o,
  output logic [AW-1:0]      mem_addr_o,
  output logic [31:0]        mem_wdata_o
);

  // Loader owns the port only when selected; otherwise the fetch PC drives the read address
  always_comb begin
    mem_we_o    = wr_en_i & loader_sel_i;
    mem_addr_o  = loader_sel_i ? ld_addr_i : fetch_waddr_i;
    mem_wdata_o = loader_sel_i ? ld_data_i : 32'h0;
  end

endmodule
`default_nettype wire

// File: rtl/imem_load_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : imem_load_ctrl
// Description : Sequences the single-port instruction memory between the
//               fetch stage and an external program loader. Holds fetch
//               during boot load / runtime patch and restarts the core at
//               BOOT_PC through the redirect path.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_load_ctrl
  import imem_load_ctrl_pkg::*;
#(
  parameter int          AW      = IMEM_AW,
  parameter bit          BOOT_EN = 1'b1,
  parameter logic [31:0] BOOT_PC = 32'h0
) (
  input  wire logic       clk_i,
  input  wire logic       reset_i,
  imem_load_ctrl_if.slave bus
);

  // Without a boot image the core restarts straight out of reset
  localparam state_t        c_RESET_ST = BOOT_EN ? ST_BOOT : ST_RESTART;
  // Memory depth; currently the full address range, kept separate so a
  // shallower memory only needs this constant changed
  localparam logic [AW:0]   c_DEPTH    = (AW+1)'(2**AW);

  state_t        state_q, state_d;
  logic [15:0]   ld_count_q, ld_count_d;
  logic          ld_err_q, ld_err_d;

  logic          ld_ready;
  logic          fetch_stall;
  logic          redirect;
  logic          loader_sel;
  logic          wr_en;
  logic          accept;
  logic          in_range;
  logic [AW-1:0] fetch_waddr;
  logic          unused_fetch_bits;

  assign accept            = bus.ld_valid & ld_ready;
  assign in_range          = ({1'b0, bus.ld_addr} < c_DEPTH);
  assign fetch_waddr       = bus.fetch_addr[AW+1:2];
  assign unused_fetch_bits = ^{bus.fetch_addr[31:AW+2], bus.fetch_addr[1:0]};

  // State register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= c_RESET_ST;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BOOT,
      ST_PATCH:   if (accept && bus.ld_last) state_d = ST_RESTART;
      ST_RESTART: state_d = ST_RUN;
      ST_RUN:     if (bus.ld_valid) state_d = ST_DRAIN;
      ST_DRAIN:   state_d = ST_PATCH;
      default:    state_d = c_RESET_ST;
    endcase
  end

  // Output decode; reset forces the core held and the memory port write-idle
  always_comb begin
    fetch_stall = 1'b1;
    redirect    = 1'b0;
    ld_ready    = 1'b0;
    loader_sel  = 1'b0;
    wr_en       = 1'b0;
    case (state_q)
      ST_BOOT,
      ST_PATCH: begin
        ld_ready   = 1'b1;
        loader_sel = 1'b1;
        wr_en      = bus.ld_valid & in_range;
      end
      ST_RESTART: begin
        fetch_stall = 1'b0;
        redirect    = 1'b1;
      end
      ST_RUN: begin
        fetch_stall = 1'b0;
      end
      default: begin
        fetch_stall = 1'b1;
      end
    endcase
    if (reset_i) begin
      fetch_stall = 1'b1;
      redirect    = 1'b0;
      wr_en       = 1'b0;
    end
  end

  // Beat counter / error flag next state; DRAIN clears them so PATCH starts fresh
  always_comb begin
    ld_count_d = ld_count_q;
    ld_err_d   = ld_err_q;
    if (state_q == ST_DRAIN) begin
      ld_count_d = 16'h0;
      ld_err_d   = 1'b0;
    end else if (accept) begin
      ld_count_d = sat_inc16(ld_count_q);
      if (!in_range) ld_err_d = 1'b1;
    end
  end

  // Beat counter / error flag registers
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ld_count_q <= 16'h0;
      ld_err_q   <= 1'b0;
    end else begin
      ld_count_q <= ld_count_d;
      ld_err_q   <= ld_err_d;
    end
  end

  imem_port_mux #(
    .AW (AW)
  ) u_port_mux (
    .loader_sel_i  (loader_sel),
    .wr_en_i       (wr_en),
    .ld_addr_i     (bus.ld_addr),
    .ld_data_i     (bus.ld_data),
    .fetch_waddr_i (fetch_waddr),
    .mem_we_o      (bus.mem_we),
    .mem_addr_o    (bus.mem_addr),
    .mem_wdata_o   (bus.mem_wdata)
  );

  assign bus.ld_ready    = ld_ready;
  assign bus.fetch_stall = fetch_stall;
  assign bus.redirect    = redirect;
  assign bus.redirect_pc = BOOT_PC;
  assign bus.ld_count    = ld_count_q;
  assign bus.ld_err      = ld_err_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_load_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_load_ctrl
// Description : Directed bench for imem_load_ctrl with a boot-image instance
//               and a preloaded-memory instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_load_ctrl;
  import imem_load_ctrl_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   wr_cnt;
  int   wr_base;
  logic [31:0] mem1 [0:1023];

  imem_load_ctrl_if #(.AW(10)) b1 ();
  imem_load_ctrl_if #(.AW(10)) b0 ();

  imem_load_ctrl #(.AW(10), .BOOT_EN(1'b1), .BOOT_PC(32'h0)) u_dut1 (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (b1)
  );

  imem_load_ctrl #(.AW(10), .BOOT_EN(1'b0), .BOOT_PC(32'h0)) u_dut0 (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (b0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model behind the boot-enabled instance
  always @(posedge clk) begin
    if (b1.mem_we) begin
      mem1[b1.mem_addr] <= b1.mem_wdata;
      wr_cnt            <= wr_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and drive one loader beat on dut1
  task automatic beat(input logic v, input logic [9:0] a, input logic [31:0] d, input logic l);
    @(negedge clk);
    b1.ld_valid = v;
    b1.ld_addr  = a;
    b1.ld_data  = d;
    b1.ld_last  = l;
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    wr_cnt = 0;
    reset  = 1'b1;
    b1.ld_valid = 1'b1; b1.ld_addr = '0; b1.ld_data = '0; b1.ld_last = 1'b0;
    b1.fetch_addr = 32'h0;
    b0.ld_valid = 1'b0; b0.ld_addr = '0; b0.ld_data = '0; b0.ld_last = 1'b0;
    b0.fetch_addr = 32'h10;

    // Reset-time decoded outputs (ld_valid held high to prove writes are gated)
    @(negedge clk); #1;
    chk("rst1_stall",    32'(b1.fetch_stall), 32'd1);
    chk("rst1_redirect", 32'(b1.redirect),    32'd0);
    chk("rst1_we",       32'(b1.mem_we),      32'd0);
    chk("rst1_ready",    32'(b1.ld_ready),    32'd1);
    chk("rst1_count",    32'(b1.ld_count),    32'd0);
    chk("rst1_err",      32'(b1.ld_err),      32'd0);
    chk("rst0_stall",    32'(b0.fetch_stall), 32'd1);
    chk("rst0_redirect", 32'(b0.redirect),    32'd0);
    chk("rst0_ready",    32'(b0.ld_ready),    32'd0);

    // Release reset together with boot beat 0
    @(negedge clk);
    reset = 1'b0;
    b1.ld_valid = 1'b1; b1.ld_addr = 10'd0; b1.ld_data = 32'h13; b1.ld_last = 1'b0;
    #1;
    chk("b0_we",        32'(b1.mem_we),      32'd1);
    chk("b0_addr",      32'(b1.mem_addr),    32'd0);
    chk("b0_stall",     32'(b1.fetch_stall), 32'd1);
    chk("nb_restart",   32'(b0.redirect),    32'd1);
    chk("nb_rst_stall", 32'(b0.fetch_stall), 32'd0);
    chk("nb_rst_we",    32'(b0.mem_we),      32'd0);

    beat(1'b1, 10'd1, 32'h13, 1'b0);
    chk("b1_we",        32'(b1.mem_we),      32'd1);
    chk("b1_addr",      32'(b1.mem_addr),    32'd1);
    chk("b1_count",     32'(b1.ld_count),    32'd1);
    chk("nb_run_redir", 32'(b0.redirect),    32'd0);
    chk("nb_run_stall", 32'(b0.fetch_stall), 32'd0);
    chk("nb_run_addr",  32'(b0.mem_addr),    32'd4);

    beat(1'b1, 10'd2, 32'h13, 1'b0);
    chk("b2_we",   32'(b1.mem_we),   32'd1);
    chk("b2_addr", 32'(b1.mem_addr), 32'd2);

    beat(1'b1, 10'd3, 32'h13, 1'b1);
    chk("b3_we",       32'(b1.mem_we),      32'd1);
    chk("b3_addr",     32'(b1.mem_addr),    32'd3);
    chk("b3_wdata",    b1.mem_wdata,        32'h13);
    chk("b3_redirect", 32'(b1.redirect),    32'd0);

    // RESTART: one cycle after the last beat
    beat(1'b0, 10'd0, 32'h0, 1'b0);
    chk("rs_redirect", 32'(b1.redirect),    32'd1);
    chk("rs_pc",       b1.redirect_pc,      32'h0);
    chk("rs_stall",    32'(b1.fetch_stall), 32'd0);
    chk("rs_ready",    32'(b1.ld_ready),    32'd0);
    chk("rs_we",       32'(b1.mem_we),      32'd0);
    chk("rs_count",    32'(b1.ld_count),    32'd4);
    chk("rs_writes",   32'(wr_cnt),         32'd4);
    chk("rs_mem3",     mem1[3],             32'h13);

    // RUN at fetch_addr 0x40
    b1.fetch_addr = 32'h40;
    beat(1'b0, 10'd0, 32'h0, 1'b0);
    chk("run_redirect", 32'(b1.redirect),    32'd0);
    chk("run_stall",    32'(b1.fetch_stall), 32'd0);
    chk("run_addr",     32'(b1.mem_addr),    32'd16);

    // Loader asks for the port while running: fetch keeps priority this cycle
    beat(1'b1, 10'd8, 32'hAAAA0001, 1'b0);
    chk("run_v_stall", 32'(b1.fetch_stall), 32'd0);
    chk("run_v_we",    32'(b1.mem_we),      32'd0);
    chk("run_v_ready", 32'(b1.ld_ready),    32'd0);

    // DRAIN
    beat(1'b1, 10'd8, 32'hAAAA0001, 1'b0);
    chk("dr_stall", 32'(b1.fetch_stall), 32'd1);
    chk("dr_addr",  32'(b1.mem_addr),    32'd16);
    chk("dr_ready", 32'(b1.ld_ready),    32'd0);
    chk("dr_we",    32'(b1.mem_we),      32'd0);
    chk("dr_count", 32'(b1.ld_count),    32'd4);
    wr_base = wr_cnt;

    // PATCH with gaps: 1,0,0,1,1-last
    beat(1'b1, 10'd8, 32'hAAAA0001, 1'b0);
    chk("p0_ready", 32'(b1.ld_ready), 32'd1);
    chk("p0_count", 32'(b1.ld_count), 32'd0);
    chk("p0_we",    32'(b1.mem_we),   32'd1);
    chk("p0_addr",  32'(b1.mem_addr), 32'd8);

    beat(1'b0, 10'd9, 32'hDEAD0000, 1'b1);
    chk("gap1_we",       32'(b1.mem_we),      32'd0);
    chk("gap1_stall",    32'(b1.fetch_stall), 32'd1);
    chk("gap1_redirect", 32'(b1.redirect),    32'd0);

    beat(1'b0, 10'd9, 32'h0, 1'b0);
    chk("gap2_stall",    32'(b1.fetch_stall), 32'd1);
    chk("gap2_redirect", 32'(b1.redirect),    32'd0);
    chk("gap2_count",    32'(b1.ld_count),    32'd1);

    beat(1'b1, 10'd9, 32'hAAAA0002, 1'b0);
    chk("p1_we", 32'(b1.mem_we), 32'd1);

    beat(1'b1, 10'd10, 32'hAAAA0003, 1'b1);
    chk("p2_we",    32'(b1.mem_we),   32'd1);
    chk("p2_count", 32'(b1.ld_count), 32'd2);

    beat(1'b0, 10'd0, 32'h0, 1'b0);
    chk("prs_redirect", 32'(b1.redirect), 32'd1);
    chk("prs_count",    32'(b1.ld_count), 32'd3);
    chk("prs_writes",   32'(wr_cnt - wr_base), 32'd3);
    chk("prs_mem9",     mem1[9],          32'hAAAA0002);

    beat(1'b0, 10'd0, 32'h0, 1'b0);
    chk("prun_redirect", 32'(b1.redirect), 32'd0);

    // Second patch, reset after two beats
    beat(1'b1, 10'd20, 32'hD1D1D1D1, 1'b0);    // RUN -> DRAIN
    beat(1'b1, 10'd20, 32'hD1D1D1D1, 1'b0);    // DRAIN
    beat(1'b1, 10'd20, 32'hD1D1D1D1, 1'b0);    // PATCH beat 20
    beat(1'b1, 10'd21, 32'hD2D2D2D2, 1'b0);    // PATCH beat 21
    beat(1'b0, 10'd0, 32'h0, 1'b0);
    chk("mid_count", 32'(b1.ld_count), 32'd2);
    wr_base = wr_cnt;
    reset = 1'b1;
    #1;
    chk("mr_stall",    32'(b1.fetch_stall), 32'd1);
    chk("mr_count",    32'(b1.ld_count),    32'd0);
    chk("mr_redirect", 32'(b1.redirect),    32'd0);
    chk("mr_ready",    32'(b1.ld_ready),    32'd1);
    chk("mr_err",      32'(b1.ld_err),      32'd0);
    chk("mr_mem20",    mem1[20],            32'hD1D1D1D1);
    chk("mr_mem21",    mem1[21],            32'hD2D2D2D2);
    chk("mr_mem0",     mem1[0],             32'h13);

    @(negedge clk);
    @(negedge clk);
    chk("mr_nowrites", 32'(wr_cnt - wr_base), 32'd0);

    // Single-beat image straight out of reset
    @(negedge clk);
    reset = 1'b0;
    b1.ld_valid = 1'b1; b1.ld_addr = 10'd5; b1.ld_data = 32'h55; b1.ld_last = 1'b1;
    #1;
    chk("sb_we",       32'(b1.mem_we),   32'd1);
    chk("sb_redirect", 32'(b1.redirect), 32'd0);

    beat(1'b0, 10'd0, 32'h0, 1'b0);
    chk("sb_rs_redirect", 32'(b1.redirect),    32'd1);
    chk("sb_count",       32'(b1.ld_count),    32'd1);
    chk("sb_err",         32'(b1.ld_err),      32'd0);
    chk("sb_writes",      32'(wr_cnt - wr_base), 32'd1);
    chk("sb_mem5",        mem1[5],             32'h55);

    beat(1'b0, 10'd0, 32'h0, 1'b0);
    chk("sb_run_redirect", 32'(b1.redirect),    32'd0);
    chk("sb_run_stall",    32'(b1.fetch_stall), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/imem_load_ctrl.md
Name: imem_load_ctrl

Overview:
- Sequences the single-port instruction memory between the fetch stage and an external program loader stream (debug/UART bridge).
- Holds the fetch stage during boot load and runtime patch, arbitrates the shared memory port, then restarts the core at BOOT_PC through the existing redirect path.
- Sits beside the fetch stage. fetch_stall drives the PC/IF-ID hold input (PCWrite, active-high hold). redirect is ORed into the branch-taken select (PCSrc).

Parameters:
- AW, 10, instruction memory word-address width (1024 words).
- BOOT_EN, 1, 1 = wait for loader image after reset; 0 = memory preloaded, restart immediately.
- BOOT_PC, 32'h0, restart address driven on redirect_pc.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- ld_valid  in  1  loader beat valid
- ld_ready  out  1  loader beat accepted this cycle when ld_valid & ld_ready
- ld_addr  in  AW  word address of beat
- ld_data  in  32  instruction word
- ld_last  in  1  final beat of image
- fetch_addr  in  32  byte PC from fetch stage
- fetch_stall  out  1  hold PC and IF/ID (active-high)
- redirect  out  1  one-cycle restart pulse to fetch mux/flush
- redirect_pc  out  32  constant BOOT_PC
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address (write or read)
- mem_wdata  out  32  memory write data
- ld_count  out  16  beats written since last BOOT/PATCH entry
- ld_err  out  1  sticky: out-of-range beat seen in current load

Behaviour:
- FSM states: BOOT, RUN, DRAIN, PATCH, RESTART. State is registered; all other outputs are decoded from state and inputs unless stated otherwise.
- Reset (async) behaviour:
  - State goes to BOOT if BOOT_EN=1, else RESTART.
  - ld_count=0, ld_err=0.
  - Decoded outputs during reset: fetch_stall=1, redirect=0, mem_we=0.
  - ld_ready=1 only if BOOT_EN=1.
  - Reset mid-load abandons the load; memory contents are not cleared.
- BOOT:
  - fetch_stall=1, ld_ready=1.
  - On each accepted beat: mem_we=1 if ld_addr < 2**AW (always true at full AW width; the check exists for future depth < 2**AW), mem_addr=ld_addr, mem_wdata=ld_data, ld_count++ (saturates at 16'hFFFF).
  - Out-of-range beat: no write, ld_err<=1, still accepted and counted.
  - Accepted beat with ld_last -> RESTART.
- RESTART (exactly 1 cycle):
  - redirect=1, fetch_stall=0, ld_ready=0, mem_we=0.
  - Next state RUN.
- RUN:
  - fetch_stall=0, ld_ready=0, mem_we=0, mem_addr=fetch_addr[AW+1:2].
  - ld_valid=1 -> DRAIN.
  - Fetch has full priority: no write ever occurs in RUN.
- DRAIN (1 cycle):
  - fetch_stall=1, ld_ready=0.
  - mem_addr keeps fetch_addr so the in-flight synchronous read completes.
  - -> PATCH; on entry to PATCH, ld_count<=0 and ld_err<=0.
- PATCH:
  - Identical to BOOT.
  - Accepted ld_last -> RESTART.
- Boundary conditions:
  - ld_valid dropping in BOOT/PATCH: remain in state, fetch_stall stays 1.
  - ld_last on a beat with ld_valid=0 is ignored.
  - Single-beat image (first beat has ld_last): write, then RESTART next cycle.
  - Back-to-back beats are accepted at 1/cycle.
  - Simultaneous ld_valid in RESTART is not accepted (ld_ready=0); it is taken via RUN -> DRAIN -> PATCH.
- Latency:
  - Loader write lands in memory at the edge ending the accept cycle.
  - redirect asserts the cycle after the ld_last beat is accepted.
  - First fetch of BOOT_PC is issued the cycle after redirect.

Decomposition:
- Shared package holds:
  - state encoding constants ST_BOOT, ST_RUN, ST_DRAIN, ST_PATCH, ST_RESTART (3-bit);
  - IMEM_AW.
- One natural sub-module: imem_port_mux, the combinational write/read address/data mux between loader and fetch.
- The FSM and counters stay in the top module.

Test Plan:
- BOOT_EN=1, reset released, 4 beats addr 0..3 data 32'h00000013, last on beat 3:
  - mem_we high 4 cycles, ld_count=4;
  - redirect=1 exactly one cycle after beat 3 with redirect_pc=0;
  - fetch_stall drops in that same cycle.
- BOOT_EN=0:
  - first cycle after reset is RESTART (redirect=1);
  - then RUN with mem_addr=fetch_addr[11:2] for fetch_addr=32'h10 -> mem_addr=4.
- In RUN with fetch_addr=32'h40, assert ld_valid:
  - fetch_stall=1 next cycle with mem_addr still 16 (DRAIN);
  - ld_ready=1 the cycle after;
  - ld_count resets to 0.
- Loader stream with ld_valid gaps (1,0,0,1,1-last):
  - exactly 3 writes, state held during gaps, single redirect.
- Assert reset mid-PATCH after 2 beats:
  - outputs immediately fetch_stall=1, ld_count=0, redirect=0;
  - state BOOT;
  - previously written words retained.
- Single-beat image with ld_last on first beat in BOOT:
  - one write, ld_count=1, redirect pulse next cycle, ld_err=0.
